// File: rtl/xs3_to_bcd_serial.sv
// xs3_to_bcd_serial: multi-digit Excess-3 to BCD decoder, one digit per clock, LSD first.
// Define XS3_ERR_EN to flag invalid codes on out_err/out_err_mask and force those digits to 4'hF.
module xs3_to_bcd_serial #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] in_xs3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd
`ifdef XS3_ERR_EN
    ,
    output logic                out_err,
    output logic [DIGITS-1:0]   out_err_mask
`endif
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t state_q, state_d;
    logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [4*DIGITS-1:0] shift_q, shift_d, bcd_q, bcd_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0] dig, dig_bcd;
    assign dig = shift_q[3:0];
`ifdef XS3_ERR_EN
    logic [DIGITS-1:0] err_q, err_d;
    logic bad;
    assign bad = dig < 4'h3 || dig > 4'hC;
    assign dig_bcd = bad ? 4'hF : dig - 4'h3;
    assign out_err = |err_q;
    assign out_err_mask = err_q;
`else
    assign dig_bcd = dig - 4'h3;
`endif
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d = bcd_q;
        idx_d = idx_q;
`ifdef XS3_ERR_EN
        err_d = err_q;
`endif
        case (state_q)
            IDLE: if (in_valid && in_ready_q) begin
                state_d = CONV;
                shift_d = in_xs3;
                bcd_d = '0;
                idx_d = '0;
`ifdef XS3_ERR_EN
                err_d = '0;
`endif
            end
            CONV: begin
                // digit under conversion always sits in the low nibble of the shifter
                shift_d = shift_q >> 4;
                idx_d = idx_q + 1'b1;
                for (int k = 0; k < DIGITS; k++) begin
                    if (idx_q == IW'(k)) begin
                        bcd_d[4*k +: 4] = dig_bcd;
`ifdef XS3_ERR_EN
                        err_d[k] = bad;
`endif
                    end
                end
                if (idx_q == LAST) state_d = DONE;
            end
            DONE: if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d = state_d == IDLE;
        out_valid_d = state_d == DONE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            in_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            shift_q <= '0;
            bcd_q <= '0;
            idx_q <= '0;
`ifdef XS3_ERR_EN
            err_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            in_ready_q <= in_ready_d;
            out_valid_q <= out_valid_d;
            shift_q <= shift_d;
            bcd_q <= bcd_d;
            idx_q <= idx_d;
`ifdef XS3_ERR_EN
            err_q <= err_d;
`endif
        end
    end
    assign in_ready = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bcd = bcd_q;
endmodule

// File: tb/tb_xs3_to_bcd_serial.sv
// tb_xs3_to_bcd_serial: randomized bench for xs3_to_bcd_serial against a per-digit arithmetic model.
module tb_xs3_to_bcd_serial;
    localparam int DIGITS = 4;
    localparam int W = 4 * DIGITS;
`ifdef XS3_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif
    logic clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_xs3, out_bcd;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
`ifdef XS3_ERR_EN
    logic out_err;
    logic [DIGITS-1:0] out_err_mask;
`endif
    xs3_to_bcd_serial #(.DIGITS(DIGITS)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_xs3(in_xs3),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bcd(out_bcd)
`ifdef XS3_ERR_EN
        ,
        .out_err(out_err),
        .out_err_mask(out_err_mask)
`endif
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [W-1:0] ref_bcd(input logic [W-1:0] w);
        logic [W-1:0] r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            int d = int'((w >> (4 * k)) & W'(15));
            int v = (ERR && (d < 3 || d > 12)) ? 15 : (d + 13) % 16;
            r = r | (W'(v) << (4 * k));
        end
        return r;
    endfunction
    function automatic logic [DIGITS-1:0] ref_mask(input logic [W-1:0] w);
        logic [DIGITS-1:0] m = '0;
        for (int k = 0; k < DIGITS; k++) begin
            int d = int'((w >> (4 * k)) & W'(15));
            m[k] = ERR && (d < 3 || d > 12);
        end
        return m;
    endfunction
    task automatic chk_result(input string tag, input logic [W-1:0] w);
        chk(tag, out_bcd, ref_bcd(w));
`ifdef XS3_ERR_EN
        chk({tag, "_mask"}, out_err_mask, ref_mask(w));
        chk({tag, "_err"}, out_err, |ref_mask(w));
`endif
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_bcd"}, out_bcd, 0);
`ifdef XS3_ERR_EN
        chk({tag, "_out_err"}, out_err, 0);
        chk({tag, "_mask"}, out_err_mask, 0);
`endif
    endtask
    // send one word; hold = cycles of backpressure after out_valid, busy = poke in_valid mid-conversion
    task automatic run_word(input logic [W-1:0] w, input int hold, input bit busy);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_xs3 = w;
        out_ready = hold == 0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", n < 50, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_xs3 = W'($urandom);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!out_valid) chk("busy_in_ready", in_ready, 0);
            in_valid = busy && n == 1;
            if (busy && n == 1) in_xs3 = {DIGITS{4'h3}};
        end while (!out_valid && n < 50);
        chk("latency", n, DIGITS);
        chk_result("result", w);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk_result("hold_bcd", w);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        chk("bcd_after", out_bcd, ref_bcd(w));
    endtask
    initial begin
        int n, t1, t2;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_xs3 = '0;
        #7 rst = 1'b1;
        #1 chk_reset("por");
        @(negedge clk);
        rst = 1'b0;
        run_word(16'h4567, 0, 1'b0);
        run_word(16'h3C2F, 0, 1'b0);
        run_word(16'h89AB, 10, 1'b0);
        run_word(16'h4567, 0, 1'b1);
        // abort mid-word after two digits converted
        @(negedge clk);
        in_valid = 1'b1;
        in_xs3 = 16'h4567;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_valid", out_valid, 0);
        end
        run_word(16'hCCCC, 0, 1'b0);
        // back-to-back with in_valid held high
        @(negedge clk);
        in_valid = 1'b1;
        in_xs3 = 16'h3456;
        @(posedge clk);
        #1 in_xs3 = 16'h7ABC;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        t1 = cyc;
        chk("b2b_first", out_bcd, 16'h0123);
        @(negedge clk);
        chk("b2b_idle", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        t2 = cyc;
        chk("b2b_second", out_bcd, 16'h4789);
        chk("b2b_spacing", t2 - t1, DIGITS + 2);
        @(negedge clk);
        for (int i = 0; i < 20; i++)
            run_word(W'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
